// File: rtl/srg_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : srg_tx_pkg
// Description : Shared definitions for the serial frame transmitter.
//               Holds the FSM state encoding, the default parameter values
//               and a helper that sizes the bit counter.
// Revision    : 1.0  initial release
// ============================================================================
package srg_tx_pkg;

    localparam int c_DATA_W_DEFAULT = 8;   // frame width in bits
    localparam int c_GAP_DEFAULT    = 1;   // idle cycles between frames (0..15)
    localparam int c_FCNT_W_DEFAULT = 16;  // width of the frame counter

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        GAP_WAIT = 2'd2
    } tx_state_e;

    // Width needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/srg.sv
`default_nettype none
// ============================================================================
// Module      : srg
// Description : Parallel-load, MSB-first shift register. Loads data_in on a
//               load cycle, otherwise shifts left by one with zero fill, so
//               the output drains to 0 once a frame has been sent.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (clears register)
//               load     - parallel load strobe
//               data_in  - parallel payload, DATA_W bits
//               s_out    - serial output (register MSB, forced 0 in reset)
// Revision    : 1.0  initial release
// ============================================================================
module srg
    import srg_tx_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              s_out
);

    logic [DATA_W-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (load) begin
            r_shift <= data_in;
        end else begin
            r_shift <= r_shift << 1;
        end
    end

    // The register still holds stale data during the reset cycle itself;
    // masking keeps the line quiet for the whole time rst is high.
    assign s_out = r_shift[DATA_W-1] & ~rst;

endmodule
`default_nettype wire

// File: rtl/srg_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : srg_tx_ctrl
// Description : Frame transmit controller. Accepts a DATA_W-bit frame on a
//               valid/ready handshake, serialises it MSB first through the
//               srg datapath, flags each payload bit and the last one, counts
//               completed frames and enforces GAP idle cycles between frames.
// Ports       : clk         - clock
//               rst         - synchronous active-high reset
//               tx_valid    - requester offers a frame
//               tx_data     - frame payload, sampled on handshake
//               tx_ready    - controller can accept a frame (IDLE, not reset)
//               s_out       - serial data, MSB first
//               bit_valid   - s_out carries a payload bit
//               bit_last    - s_out carries the final payload bit
//               frames_sent - completed frame count, wraps
// Revision    : 1.0  initial release
// ============================================================================
module srg_tx_ctrl
    import srg_tx_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int GAP    = c_GAP_DEFAULT,
    parameter int FCNT_W = c_FCNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              s_out,
    output logic              bit_valid,
    output logic              bit_last,
    output logic [FCNT_W-1:0] frames_sent
);

    localparam int                    c_BCNT_W   = cnt_width(DATA_W);
    localparam logic [c_BCNT_W-1:0]   c_BIT_LAST = c_BCNT_W'(DATA_W - 1);
    // Last gap-counter value; unused when GAP is zero.
    localparam logic [3:0]            c_GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic                  c_ONE_BIT  = (DATA_W == 1);

    tx_state_e             r_state;
    logic [c_BCNT_W-1:0]   r_bit_cnt;
    logic [3:0]            r_gap_cnt;
    logic [FCNT_W-1:0]     r_frames;
    logic                  r_bit_valid;
    logic                  r_bit_last;

    logic                  w_handshake;
    logic                  w_load;

    assign tx_ready    = (r_state == IDLE) & ~rst;
    assign w_handshake = tx_valid & tx_ready;
    // Load fires in the handshake cycle so the first payload bit is on
    // s_out right after the accepting edge.
    assign w_load      = w_handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_frames    <= '0;
            r_bit_valid <= 1'b0;
            r_bit_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_state     <= SHIFT;
                        r_bit_cnt   <= '0;
                        r_bit_valid <= 1'b1;
                        r_bit_last  <= c_ONE_BIT;
                    end
                end

                SHIFT: begin
                    if (r_bit_cnt == c_BIT_LAST) begin
                        r_frames    <= r_frames + FCNT_W'(1);
                        r_bit_cnt   <= '0;
                        r_bit_valid <= 1'b0;
                        r_bit_last  <= 1'b0;
                        if (GAP > 0) begin
                            r_state   <= GAP_WAIT;
                            r_gap_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_bit_cnt  <= r_bit_cnt + c_BCNT_W'(1);
                        // Flag the upcoming cycle if it will carry the LSB.
                        r_bit_last <= ((r_bit_cnt + c_BCNT_W'(1)) == c_BIT_LAST);
                    end
                end

                GAP_WAIT: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state   <= IDLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Registered flags are masked so they drop immediately while rst is high.
    assign bit_valid   = r_bit_valid & ~rst;
    assign bit_last    = r_bit_last & ~rst;
    assign frames_sent = r_frames;

    srg #(
        .DATA_W (DATA_W)
    ) u_srg (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .data_in (tx_data),
        .s_out   (s_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_srg_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_srg_tx_ctrl
// Description : Self-checking bench for srg_tx_ctrl. Three instances share
//               one stimulus stream: GAP=0/FCNT_W=4, GAP=1 (defaults) and
//               GAP=2. Each is compared every cycle against a timeline model
//               that tracks, per instance, the accepted frame's start cycle
//               and the first cycle in which a new frame may be accepted.
// Revision    : 1.0  initial release
// ============================================================================
module tb_srg_tx_ctrl;

    localparam int DW = 8;
    localparam int NI = 3;
    localparam int GAPS  [NI] = '{0, 1, 2};
    localparam int FMASK [NI] = '{15, 65535, 65535};

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [DW-1:0] tx_data;

    logic          obs_ready [NI];
    logic          obs_sout  [NI];
    logic          obs_bv    [NI];
    logic          obs_bl    [NI];
    logic [3:0]    fs0;
    logic [15:0]   fs1;
    logic [15:0]   fs2;

    always #5 clk = ~clk;

    srg_tx_ctrl #(.DATA_W(DW), .GAP(0), .FCNT_W(4)) u_dut_g0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(obs_ready[0]), .s_out(obs_sout[0]), .bit_valid(obs_bv[0]),
        .bit_last(obs_bl[0]), .frames_sent(fs0)
    );

    srg_tx_ctrl #(.DATA_W(DW), .GAP(1), .FCNT_W(16)) u_dut_g1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(obs_ready[1]), .s_out(obs_sout[1]), .bit_valid(obs_bv[1]),
        .bit_last(obs_bl[1]), .frames_sent(fs1)
    );

    srg_tx_ctrl #(.DATA_W(DW), .GAP(2), .FCNT_W(16)) u_dut_g2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(obs_ready[2]), .s_out(obs_sout[2]), .bit_valid(obs_bv[2]),
        .bit_last(obs_bl[2]), .frames_sent(fs2)
    );

    // Reference model state. n is the index of the current cycle (cycle n
    // follows edge n).
    int            n;
    int            m_ready_from [NI];
    int            m_start      [NI];
    bit            m_act        [NI];
    logic [DW-1:0] m_data       [NI];
    int            m_frames     [NI];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Compare all outputs of every instance against the model for cycle n.
    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            logic          e_ready, e_bv, e_bl, e_bit;
            logic [DW-1:0] d;
            logic [31:0]   got_fs;
            bit            in_frame;
            in_frame = m_act[i] && (n >= m_start[i]) && (n <= m_start[i] + DW - 1);
            d        = m_data[i];
            e_ready  = !rst && (n >= m_ready_from[i]);
            e_bv     = !rst && in_frame;
            e_bl     = e_bv && (n == m_start[i] + DW - 1);
            e_bit    = e_bv ? d[DW-1-(n-m_start[i])] : 1'b0;
            case (i)
                0:       got_fs = 32'(fs0);
                1:       got_fs = 32'(fs1);
                default: got_fs = 32'(fs2);
            endcase
            check($sformatf("g%0d tx_ready", i),    32'(obs_ready[i]), 32'(e_ready));
            check($sformatf("g%0d bit_valid", i),   32'(obs_bv[i]),    32'(e_bv));
            check($sformatf("g%0d bit_last", i),    32'(obs_bl[i]),    32'(e_bl));
            check($sformatf("g%0d s_out", i),       32'(obs_sout[i]),  32'(e_bit));
            check($sformatf("g%0d frames_sent", i), got_fs,            32'(m_frames[i]));
        end
    endtask

    // Advance the model across the edge that ends cycle n.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_act[i]        = 1'b0;
                m_frames[i]     = 0;
                m_ready_from[i] = n + 1;
            end else begin
                if (m_act[i] && (n == m_start[i] + DW - 1)) begin
                    m_frames[i] = (m_frames[i] + 1) & FMASK[i];
                    m_act[i]    = 1'b0;
                end
                if (tx_valid && (n >= m_ready_from[i])) begin
                    m_act[i]        = 1'b1;
                    m_start[i]      = n + 1;
                    m_data[i]       = tx_data;
                    // DW shift cycles, GAP wait cycles, then ready again.
                    m_ready_from[i] = n + 1 + DW + GAPS[i];
                end
            end
        end
        n++;
    endtask

    // Apply inputs for one cycle, check that cycle, then cross the edge.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d);
        rst      = r;
        tx_valid = v;
        tx_data  = d;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        n = 0;
        for (int i = 0; i < NI; i++) begin
            m_ready_from[i] = 0;
            m_start[i]      = 0;
            m_act[i]        = 1'b0;
            m_data[i]       = '0;
            m_frames[i]     = 0;
        end
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        @(posedge clk);
        model_edge();
        #1;

        // Reset held, with a valid offer that must be ignored.
        step(1'b1, 1'b1, 8'hA5);
        step(1'b1, 1'b0, 8'h00);

        // Single frame 10111011.
        step(1'b0, 1'b1, 8'b1011_1011);
        for (int c = 0; c < 14; c++) step(1'b0, 1'b0, 8'h00);

        // Continuous offer: BB then 5A, data changes while shifting.
        step(1'b0, 1'b1, 8'hBB);
        for (int c = 0; c < 24; c++) step(1'b0, 1'b1, 8'h5A);
        for (int c = 0; c < 14; c++) step(1'b0, 1'b0, 8'h00);

        // Abort after three bits of FF.
        step(1'b0, 1'b1, 8'hFF);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h33);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 8'h00);

        // Long continuous run: wraps the 4-bit counter, new data every cycle.
        for (int c = 0; c < 220; c++) step(1'b0, 1'b1, DW'($urandom));

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 DW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
